// File: rtl/fault_log_pkg.sv
// Shared record layout, frame constants and serializer state
// for the fault event logger.
package fault_log_pkg;

    localparam int REC_W      = 8;
    localparam int FRAME_BITS = 10;
    localparam int CLASS_LSB  = 6;
    localparam int CODE_LSB   = 3;
    localparam int Q_BIT      = 2;
    localparam int SEQ_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [1:0]       cls,
        input logic [2:0]       code,
        input logic             q,
        input logic [SEQ_W-1:0] seq
    );
        logic [REC_W-1:0] r;
        r                  = '0;
        r[CLASS_LSB +: 2]  = cls;
        r[CODE_LSB +: 3]   = code;
        r[Q_BIT]           = q;
        r[SEQ_W-1:0]       = seq;
        return r;
    endfunction

endpackage

// File: rtl/fault_log_uart_tx.sv
// 8N1 serializer: pops one record from the FIFO when idle and
// shifts it out LSB first with registered tx/busy.
module fault_log_uart_tx
    import fault_log_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             empty_i,
    input  logic [REC_W-1:0] data_i,
    output logic             pop_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int             BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);
    localparam logic [2:0]     BIT_LAST  = 3'(FRAME_BITS - 3);

    tx_state_e        state_q;
    logic [BW-1:0]    baud_q;
    logic [2:0]       bit_q;
    logic [REC_W-1:0] shift_q;
    logic             tx_q;
    logic             busy_q;
    logic             ready;
    logic             baud_done;

    assign ready     = (state_q == IDLE);
    assign pop_o     = ready && !empty_i;
    assign baud_done = (baud_q == BAUD_LAST);
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            // Baud counter restarts at every bit boundary and rests at 0 in IDLE.
            if (ready || baud_done) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + BAUD_ONE;
            end

            case (state_q)
                IDLE: begin
                    if (pop_o) begin
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        if (bit_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fault_event_logger.sv
// Detects new fault tuples, packs them into sequenced records,
// buffers them in a FIFO and drains them over an 8N1 line.
module fault_event_logger
    import fault_log_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BAUD_DIV = 16,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     q_in,
    input  logic [2:0]               fault_code,
    input  logic [1:0]               fault_class,
    input  logic                     clr,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [CNT_W-1:0]         event_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int               AW      = $clog2(DEPTH);
    localparam int               TW      = 6;
    localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

    logic [TW-1:0]    tuple;
    logic [TW-1:0]    prev_q;
    logic             evt;
    logic [REC_W-1:0] rec;

    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign tuple = {fault_class, fault_code, q_in};
    assign evt   = (fault_code != 3'd0) && (tuple != prev_q);
    assign rec   = pack_record(fault_class, fault_code, q_in, seq_q);

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    // A same-edge pop frees the slot the push needs.
    assign push  = evt && (!full || pop);

    always_comb begin
        seq_d = seq_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        wr_d  = wr_q;
        rd_d  = rd_q;

        if (push) begin
            wr_d = wr_q + PTR_ONE;
        end
        if (pop) begin
            rd_d = rd_q + PTR_ONE;
        end

        if (clr) begin
            seq_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (evt) begin
            seq_d = seq_q + SEQ_ONE;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (!push) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            seq_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
        end else begin
            prev_q <= tuple;
            seq_q  <= seq_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= rec;
        end
    end

    fault_log_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .empty_i (empty),
        .data_i  (mem_q[rd_q[AW-1:0]]),
        .pop_o   (pop),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    assign overflow    = ovf_q;
    assign event_count = cnt_q;
    assign fifo_level  = wr_q - rd_q;

endmodule

// File: tb/tb_fault_event_logger.sv
// Directed bench for fault_event_logger with DEPTH=8, BAUD_DIV=16,
// CNT_W=8; frames are decoded by mid-bit sampling of tx.
module tb_fault_event_logger;

    logic       clk = 1'b0;
    logic       reset;
    logic       q_in;
    logic [2:0] fault_code;
    logic [1:0] fault_class;
    logic       clr;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [7:0] event_count;
    logic [3:0] fifo_level;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] b;

    always #5 clk = ~clk;

    fault_event_logger #(
        .DEPTH    (8),
        .BAUD_DIV (16),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .q_in        (q_in),
        .fault_code  (fault_code),
        .fault_class (fault_class),
        .clr         (clr),
        .tx          (tx),
        .busy        (busy),
        .overflow    (overflow),
        .event_count (event_count),
        .fifo_level  (fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ev(input int i);
        fault_code  = 3'((i % 7) + 1);
        fault_class = 2'((i / 7) % 4);
        q_in        = 1'(i % 2);
    endtask

    function automatic logic [7:0] ev_rec(input int i, input int s);
        return {2'((i / 7) % 4), 3'((i % 7) + 1), 1'(i % 2), 2'(s % 4)};
    endfunction

    // skip = cycles already elapsed since the edge where tx fell
    task automatic rx_frame(input int skip, output logic [7:0] d);
        d = '0;
        if (skip < 8) tick(8 - skip);
        check("start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(16);
            d[i] = tx;
        end
        tick(16);
        check("stop_bit", tx, 1'b1);
    endtask

    task automatic wait_start();
        int n = 0;
        while (tx !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check("start_timeout", 32'(n < 400), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 400), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr = 1'b0;
        q_in = 1'b0;
        fault_code = 3'd0;
        fault_class = 2'd0;
        tick(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_cnt", event_count, 0);
        check("rst_lvl", fifo_level, 0);
        reset = 1'b0;
        tick();

        // Single event -> 0xAC
        fault_class = 2'd2;
        fault_code = 3'd5;
        q_in = 1'b1;
        tick();
        check("ev1_lvl", fifo_level, 1);
        check("ev1_cnt", event_count, 1);
        check("ev1_tx_idle", tx, 1);
        tick();
        check("ev1_lvl_pop", fifo_level, 0);
        check("ev1_busy", busy, 1);
        rx_frame(0, b);
        check("ev1_rec", b, 8'hAC);
        tick(7);
        check("ev1_busy159", busy, 1);
        tick(1);
        check("ev1_busy160", busy, 0);

        // Held tuple and fault_code=0 produce nothing
        tick(100);
        check("hold_cnt", event_count, 1);
        check("hold_lvl", fifo_level, 0);
        check("hold_busy", busy, 0);
        fault_code = 3'd0;
        fault_class = 2'd3;
        q_in = 1'b0;
        tick(5);
        fault_class = 2'd1;
        q_in = 1'b1;
        tick(5);
        check("zero_cnt", event_count, 1);
        check("zero_lvl", fifo_level, 0);
        check("zero_tx", tx, 1);

        // Overflow: 10 events back to back
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt", event_count, 0);
        for (int i = 0; i < 10; i++) begin
            drive_ev(i);
            tick();
        end
        check("ovf_lvl", fifo_level, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_cnt", event_count, 10);
        fault_code = 3'd0;
        rx_frame(8, b);
        check("ovf_rec0", b, ev_rec(0, 0));
        for (int k = 1; k < 9; k++) begin
            wait_start();
            rx_frame(0, b);
            check($sformatf("ovf_rec%0d", k), b, ev_rec(k, k));
        end
        wait_idle();
        check("ovf_drained", fifo_level, 0);
        check("ovf_sticky", overflow, 1);

        // Full FIFO with a same-edge pop
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ovf", overflow, 0);
        for (int i = 0; i < 9; i++) begin
            drive_ev(i);
            tick();
        end
        fault_code = 3'd0;
        check("full_lvl", fifo_level, 8);
        wait_idle();
        drive_ev(20);
        tick();
        check("sp_lvl", fifo_level, 8);
        check("sp_ovf", overflow, 0);
        check("sp_busy", busy, 1);
        check("sp_cnt", event_count, 10);
        fault_code = 3'd0;
        for (int k = 1; k < 9; k++) begin
            wait_start();
            rx_frame(0, b);
            check($sformatf("sp_rec%0d", k), b, ev_rec(k, k));
        end
        wait_start();
        rx_frame(0, b);
        check("sp_rec_late", b, ev_rec(20, 1));
        wait_idle();

        // clr coincident with an event at count 7
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_ev(i);
            tick();
        end
        check("cc_cnt7", event_count, 7);
        drive_ev(7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("cc_cnt", event_count, 0);
        check("cc_ovf", overflow, 0);
        check("cc_lvl", fifo_level, 7);
        drive_ev(8);
        tick();
        check("cc_cnt_after", event_count, 1);
        fault_code = 3'd0;
        rx_frame(7, b);
        check("cc_rec0", b, ev_rec(0, 0));
        for (int k = 1; k < 9; k++) begin
            wait_start();
            rx_frame(0, b);
            check($sformatf("cc_rec%0d", k), b,
                  ev_rec(k, (k == 8) ? 0 : k));
        end
        wait_idle();

        // Counter saturation, then clr keeps the FIFO
        clr = 1'b1;
        tick();
        clr = 1'b0;
        fault_code = 3'd1;
        fault_class = 2'd0;
        for (int i = 0; i < 260; i++) begin
            q_in = 1'(i % 2);
            tick();
        end
        fault_code = 3'd0;
        check("sat_cnt", event_count, 255);
        check("sat_ovf", overflow, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sat_clr_cnt", event_count, 0);
        check("sat_clr_ovf", overflow, 0);
        check("sat_clr_lvl", fifo_level, 8);

        // Asynchronous reset in the middle of DATA
        wait_start();
        tick(40);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #2;
        check("ar_tx", tx, 1);
        check("ar_busy", busy, 0);
        check("ar_lvl", fifo_level, 0);
        check("ar_cnt", event_count, 0);
        tick();
        reset = 1'b0;
        tick(2);
        fault_class = 2'd2;
        fault_code = 3'd5;
        q_in = 1'b1;
        tick(2);
        check("ar_busy_new", busy, 1);
        rx_frame(0, b);
        check("ar_rec", b, 8'hAC);
        wait_idle();
        check("ar_end_lvl", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
